pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl_pkg.sv | 15 +
 rtl/pc_target_sel.sv | 31 +++
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - NPC operation codes and fetch FSM states
package pc_fetch_ctrl_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        FS_BOOT     = 2'd0,
        FS_RUN      = 2'd1,
        FS_MEM_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - priority select of EX-stage redirect target and npc op
module pc_target_sel
    import pc_fetch_ctrl_pkg::*;
(
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_aluout,
    output logic        redirect,
    output logic [31:0] target,
    output logic [2:0]  npc_op
);

    assign redirect = jalr | jal | branch_taken;

    always_comb begin
        target = ex_pc + ex_imm;
        npc_op = NPC_PLUS4;
        if (jalr) begin
            target = {ex_aluout[31:1], 1'b0};
            npc_op = NPC_JALR;
        end else if (jal) begin
            npc_op = NPC_JUMP;
        end else if (branch_taken) begin
            npc_op = NPC_BRANCH;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch PC register, redirect/stall/wait scheduling
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ex_branch_taken,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_aluout,
    input  logic             ld_use_stall,
    input  logic             imem_ready,
    output logic [31:0]      pc_out,
    output logic [2:0]       npc_op,
    output logic             fetch_valid,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] redirect_count
);

    fetch_state_t state;
    logic         redirect_raw;
    logic         redirect;
    logic [31:0]  target;
    logic [2:0]   sel_op;
    logic [31:0]  pending_target;
    logic         pending_valid;
    logic [31:0]  pc_plus4;

    pc_target_sel u_target_sel (
        .branch_taken (ex_branch_taken),
        .jal          (ex_jal),
        .jalr         (ex_jalr),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_aluout    (ex_aluout),
        .redirect     (redirect_raw),
        .target       (target),
        .npc_op       (sel_op)
    );

    // BOOT ignores EX-stage traffic; nothing valid is in flight yet.
    assign redirect    = redirect_raw && (state != FS_BOOT);
    assign npc_op      = redirect ? sel_op : NPC_PLUS4;
    assign if_id_flush = redirect;
    assign id_ex_flush = redirect || ((state == FS_RUN) && ld_use_stall);
    assign pc_plus4    = pc_out + 32'd4;

    always_comb begin
        if_id_write = 1'b0;
        case (state)
            FS_BOOT:     if_id_write = 1'b1;
            FS_RUN:      if_id_write = redirect || (!ld_use_stall && imem_ready);
            default:     if_id_write = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= FS_BOOT;
            pc_out         <= RESET_PC;
            fetch_valid    <= 1'b0;
            pending_target <= 32'd0;
            pending_valid  <= 1'b0;
            redirect_count <= '0;
        end else begin
            if (redirect && (redirect_count != {CNT_W{1'b1}}))
                redirect_count <= redirect_count + 1'b1;

            case (state)
                FS_BOOT: begin
                    state       <= FS_RUN;
                    fetch_valid <= 1'b1;
                end
                FS_RUN: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc_out <= target;
                        end else begin
                            pending_target <= target;
                            pending_valid  <= 1'b1;
                            state          <= FS_MEM_WAIT;
                        end
                    end else if (ld_use_stall) begin
                        state <= FS_RUN;
                    end else if (!imem_ready) begin
                        state <= FS_MEM_WAIT;
                    end else begin
                        pc_out <= pc_plus4;
                    end
                end
                FS_MEM_WAIT: begin
                    if (imem_ready) begin
                        if (redirect)
                            pc_out <= target;
                        else if (pending_valid)
                            pc_out <= pending_target;
                        else
                            pc_out <= pc_plus4;
                        pending_valid <= 1'b0;
                        state         <= FS_RUN;
                    end else if (redirect) begin
                        pending_target <= target;
                        pending_valid  <= 1'b1;
                    end
                end
                default: state <= FS_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_branch_taken, ex_jal, ex_jalr;
    logic [31:0] ex_pc, ex_imm, ex_aluout;
    logic        ld_use_stall, imem_ready;
    logic [31:0] pc_out;
    logic [2:0]  npc_op;
    logic        fetch_valid, if_id_write, if_id_flush, id_ex_flush;
    logic [15:0] redirect_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ex_branch_taken (ex_branch_taken),
        .ex_jal          (ex_jal),
        .ex_jalr         (ex_jalr),
        .ex_pc           (ex_pc),
        .ex_imm          (ex_imm),
        .ex_aluout       (ex_aluout),
        .ld_use_stall    (ld_use_stall),
        .imem_ready      (imem_ready),
        .pc_out          (pc_out),
        .npc_op          (npc_op),
        .fetch_valid     (fetch_valid),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .redirect_count  (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_branch_taken = 1'b0;
        ex_jal          = 1'b0;
        ex_jalr         = 1'b0;
        ld_use_stall    = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        clear_ex();
        ex_pc = 32'd0; ex_imm = 32'd0; ex_aluout = 32'd0;
        imem_ready = 1'b1;
        #3;
        check("rst_pc", pc_out, 32'h0);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_wr", {31'd0, if_id_write}, 32'd1);
        check("rst_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        check("rst_op", {29'd0, npc_op}, 32'd0);
        check("rst_cnt", {16'd0, redirect_count}, 32'd0);

        tick(); rstn = 1'b1;
        check("boot_pc", pc_out, 32'h0);
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("run_pc0", pc_out, 32'h0);
        check("run_fv", {31'd0, fetch_valid}, 32'd1);
        tick(); check("seq_4", pc_out, 32'h4);
        tick(); check("seq_8", pc_out, 32'h8);
        tick(); check("seq_c", pc_out, 32'hC);
        check("seq_op", {29'd0, npc_op}, 32'd0);
        tick(); check("seq_10", pc_out, 32'h10);

        ex_branch_taken = 1'b1; ex_pc = 32'h8; ex_imm = 32'h20;
        #1;
        check("br_op", {29'd0, npc_op}, 32'd1);
        check("br_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        tick(); clear_ex();
        check("br_pc", pc_out, 32'h28);
        check("br_cnt", {16'd0, redirect_count}, 32'd1);

        ex_jalr = 1'b1; ex_jal = 1'b1; ld_use_stall = 1'b1;
        ex_aluout = 32'h103; ex_pc = 32'h28; ex_imm = 32'h400;
        #1;
        check("jalr_op", {29'd0, npc_op}, 32'd4);
        check("jalr_ctl", {29'd0, id_ex_flush, if_id_flush, if_id_write}, 32'd7);
        tick(); clear_ex();
        check("jalr_pc", pc_out, 32'h102);
        check("jalr_cnt", {16'd0, redirect_count}, 32'd2);

        ex_jal = 1'b1; ex_pc = 32'h10; ex_imm = 32'h10;
        #1;
        check("jal_op", {29'd0, npc_op}, 32'd2);
        tick(); clear_ex();
        check("jal_pc", pc_out, 32'h20);

        ld_use_stall = 1'b1;
        #1;
        check("stall_ctl", {29'd0, if_id_write, id_ex_flush, if_id_flush}, 32'd2);
        tick(); clear_ex();
        check("stall_pc", pc_out, 32'h20);
        tick(); check("stall_next", pc_out, 32'h24);

        ex_branch_taken = 1'b1; ex_pc = 32'h30; ex_imm = 32'h10; imem_ready = 1'b0;
        #1;
        check("wait_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        tick(); clear_ex();
        check("wait_pc1", pc_out, 32'h24);
        check("wait_wr1", {31'd0, if_id_write}, 32'd0);
        check("wait_cnt", {16'd0, redirect_count}, 32'd4);
        tick();
        check("wait_pc2", pc_out, 32'h24);
        check("wait_fv2", {30'd0, fetch_valid, if_id_write}, 32'd2);
        imem_ready = 1'b1;
        #1;
        check("wait_wr3", {31'd0, if_id_write}, 32'd0);
        tick();
        check("wait_pc_tgt", pc_out, 32'h40);
        check("wait_cnt2", {16'd0, redirect_count}, 32'd4);

        ex_branch_taken = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h8;
        repeat (65540) tick();
        check("sat_cnt", {16'd0, redirect_count}, 32'h0000_FFFF);
        check("sat_pc", pc_out, 32'hFFFF_FFF8);
        clear_ex();
        tick(); check("wrap_fc", pc_out, 32'hFFFF_FFFC);
        tick(); check("wrap_0", pc_out, 32'h0);
        tick(); check("wrap_4", pc_out, 32'h4);

        ex_jalr = 1'b1; ex_aluout = 32'h81; imem_ready = 1'b0;
        tick(); clear_ex();
        check("mw_pc", pc_out, 32'h4);
        check("mw_cnt_sat", {16'd0, redirect_count}, 32'h0000_FFFF);
        #2; rstn = 1'b0;
        #1;
        check("mw_rst_pc", pc_out, 32'h0);
        check("mw_rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("mw_rst_cnt", {16'd0, redirect_count}, 32'd0);
        tick(); imem_ready = 1'b1; rstn = 1'b1;
        check("rb_boot", pc_out, 32'h0);
        tick(); check("rb_pc0", pc_out, 32'h0);
        tick(); check("rb_pc4", pc_out, 32'h4);
        tick(); check("rb_pc8", pc_out, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
